mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's memory handshake: the control unit drives address, opcode and write data from MAR/MDR, and raises `Enable`; this block performs the access against a 256-byte big-endian array and answers with `MFC` (memory function complete). It replaces the zero-latency RAM model with a cycle-accurate responder that has a programmable latency, a four-phase handshake, abort-on-withdraw and misalignment detection. It sits between the datapath's MAR/MDR registers and the control unit's MFC input.

## Interface
- `LATENCY`, 2, cycles from request acceptance to `MFC` rising; legal range 1..15.
- `Clk`  in  1  system clock, rising-edge.
- `Clr`  in  1  reset, asynchronous, active-high.
- `Enable`  in  1  request strobe from the control unit; held high until `MFC` is observed.
- `RW`  in  1  1 = read, 0 = write.
- `Size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `Addr`  in  8  byte address (from MAR).
- `DataIn`  in  32  write data (from MDR), right-justified for byte/halfword.
- `DataOut`  out  32  read data, right-justified, zero-extended.
- `MFC`  out  1  access complete; held high while `Enable` stays high.
- `Misaligned`  out  1  qualifies `MFC`: access was misaligned and suppressed.

## Operation
- Storage: 256 x 8 array, big-endian: byte at `Addr` is the most significant byte of a halfword/word. Contents are not cleared by `Clr`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: at a rising edge with `Enable`=1, latch `RW`, `Size`, `Addr`, `DataIn`; load counter with `LATENCY`-1; go to BUSY.
  - BUSY: counter decrements each edge. At the edge where the counter is 0, perform the access, set `MFC`=1, go to DONE. If `Enable`=0 at any BUSY edge, abort: no write, `MFC` stays 0, go to IDLE.
  - DONE: hold `MFC`, `DataOut`, `Misaligned`. At the first edge with `Enable`=0, clear `MFC` and `Misaligned`, go to IDLE.
- Read: word = {M[a],M[a+1],M[a+2],M[a+3]}; halfword = {16'h0,M[a],M[a+1]}; byte = {24'h0,M[a]}.
- Write: same byte mapping from `DataIn[31:0]`/`[15:0]`/`[7:0]`; untouched bytes are preserved.
- Alignment: halfword requires `Addr[0]`=0; word requires `Addr[1:0]`=0. Aligned accesses never wrap past byte 255.
- Inputs other than `Enable` are ignored outside the IDLE acceptance edge.

## Timing
- Reset values: `MFC`=0, `Misaligned`=0, `DataOut`=32'h0, state IDLE, counter 0.
- Request accepted at edge E0; `MFC`, `DataOut` and the write commit all occur at edge E0+`LATENCY`.
- `DataOut` keeps its last read value after DONE until the next read completes; writes do not change it.
- `MFC` falls one edge after `Enable` falls; earliest next acceptance is the edge after that. Minimum round-trip is `LATENCY`+2 cycles.
- `Clr` during BUSY: access aborted, no write, outputs go to reset values immediately (asynchronous).
- `Enable` falling on the same edge the counter reaches 0: abort wins; no write, no `MFC`.

## Configuration
- `MEM_RESP_MISALIGN_TRAP_EN` defined: misaligned access completes normally in time but with `Misaligned`=1, no write, `DataOut` unchanged.
- Not defined: `Misaligned` is tied to 0; low address bits are forced to alignment (halfword clears `Addr[0]`, word clears `Addr[1:0]`) and the access proceeds.

## Test plan
- Word write 32'hDEADBEEF to 8'h10, then byte reads of 8'h10..8'h13 -> DataOut 32'hDE, 32'hAD, 32'hBE, 32'hEF; `MFC` rises exactly `LATENCY` edges after each acceptance.
- Halfword write 16'h1234 to 8'h22 over preloaded word 32'hAABBCCDD at 8'h20 -> word read of 8'h20 returns 32'hAABB1234.
- Drop `Enable` one cycle after acceptance of a write 32'h55555555 to 8'h40 (`LATENCY`=3) -> `MFC` never rises; word read of 8'h40 returns prior contents.
- Hold `Enable` high 5 cycles after `MFC` -> `MFC` and `DataOut` stable; lower `Enable` -> `MFC`=0 next edge; new request accepted the edge after.
- Word write to 8'h41: with macro -> `MFC`=1, `Misaligned`=1, memory unchanged; without macro -> write lands at 8'h40, `Misaligned`=0.
- Assert `Clr` mid-BUSY -> `MFC`=0, `DataOut`=0 asynchronously; no write committed; next request completes normally.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-to-memory request/complete handshake bundle.
// master = control unit side, slave = memory responder side.
interface mem_responder_if;
  logic        Enable;
  logic        RW;
  logic [1:0]  Size;
  logic [7:0]  Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Misaligned;

  modport master (
    output Enable, RW, Size, Addr, DataIn,
    input  DataOut, MFC, Misaligned
  );

  modport slave (
    input  Enable, RW, Size, Addr, DataIn,
    output DataOut, MFC, Misaligned
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 256-byte big-endian memory with programmable latency MFC handshake.
// Optional MEM_RESP_MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning.
module mem_responder #(
  parameter int unsigned LATENCY = 2
) (
  input  logic            Clk,
  input  logic            Clr,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic        mfc_q;
  logic        mis_q;
  logic [31:0] dout_q;

  logic        accept;
  logic        fire;
  logic        mis;
  logic        we;
  logic [7:0]  ea;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rdata;

  logic [7:0]  mem [256];

`ifdef MEM_RESP_MISALIGN_TRAP_EN
  assign mis = (size_q == 2'b01 && addr_q[0]) ||
               (size_q[1] && addr_q[1:0] != 2'b00);
  assign ea  = addr_q;
`else
  assign mis = 1'b0;
  assign ea  = (size_q == 2'b01) ? {addr_q[7:1], 1'b0} :
               size_q[1]         ? {addr_q[7:2], 2'b00} :
                                   addr_q;
`endif

  assign b0 = mem[ea];
  assign b1 = mem[ea + 8'd1];
  assign b2 = mem[ea + 8'd2];
  assign b3 = mem[ea + 8'd3];

  // Right-justified, zero-extended read data for the latched size.
  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      size_q == 2'b00: rdata = {24'h0, b0};
      size_q == 2'b01: rdata = {16'h0, b0, b1};
      default:         rdata = {b0, b1, b2, b3};
    endcase
  end

  // Next-state logic; withdrawing Enable in BUSY beats the final count.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Enable) begin
          state_d = BUSY;
          accept  = 1'b1;
        end
      end
      BUSY: begin
        if (!bus.Enable) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      DONE: begin
        if (!bus.Enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign we = fire && !rw_q && !mis;

  // State register.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, latency counter and response outputs.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cnt_q  <= 4'd0;
      rw_q   <= 1'b0;
      size_q <= 2'b00;
      addr_q <= 8'h0;
      data_q <= 32'h0;
      mfc_q  <= 1'b0;
      mis_q  <= 1'b0;
      dout_q <= 32'h0;
    end else begin
      if (accept) begin
        cnt_q  <= 4'(LATENCY - 1);
        rw_q   <= bus.RW;
        size_q <= bus.Size;
        addr_q <= bus.Addr;
        data_q <= bus.DataIn;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (fire) begin
        mfc_q <= 1'b1;
        mis_q <= mis;
        if (rw_q && !mis) dout_q <= rdata;
      end else if (state_q == DONE && !bus.Enable) begin
        mfc_q <= 1'b0;
        mis_q <= 1'b0;
      end
    end
  end

  // Storage write; contents survive Clr.
  always_ff @(posedge Clk) begin
    if (we) begin
      unique case (1'b1)
        size_q == 2'b00: mem[ea] <= data_q[7:0];
        size_q == 2'b01: begin
          mem[ea]        <= data_q[15:8];
          mem[ea + 8'd1] <= data_q[7:0];
        end
        default: begin
          mem[ea]        <= data_q[31:24];
          mem[ea + 8'd1] <= data_q[23:16];
          mem[ea + 8'd2] <= data_q[15:8];
          mem[ea + 8'd3] <= data_q[7:0];
        end
      endcase
    end
  end

  assign bus.MFC        = mfc_q;
  assign bus.Misaligned = mis_q;
  assign bus.DataOut    = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
// Expectations follow MEM_RESP_MISALIGN_TRAP_EN when it is defined.
module tb_mem_responder;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] d;
    logic        m;
    int          c;
  } exp_t;

  logic Clk = 1'b0;
  logic Clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic [31:0] exp_dout = 32'h0;
  logic mfc_prev = 1'b0;
  exp_t sb [$];

`ifdef MEM_RESP_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  mem_responder_if bus ();

  mem_responder #(.LATENCY(LAT)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every MFC rise pops one expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (bus.MFC && !mfc_prev) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_mfc", 32'(bus.MFC), 32'h0);
      end else begin
        e = sb.pop_front();
        chk(bus.DataOut === e.d, "dataout", bus.DataOut, e.d);
        chk(bus.Misaligned === e.m, "misaligned",
            32'(bus.Misaligned), 32'(e.m));
        chk(cyc == e.c, "mfc_latency", 32'(cyc), 32'(e.c));
      end
    end
    mfc_prev = bus.MFC;
  end

  task automatic drive(input logic rw, input logic [1:0] sz,
                       input logic [7:0] a, input logic [31:0] d);
    @(negedge Clk);
    bus.Enable = 1'b1;
    bus.RW     = rw;
    bus.Size   = sz;
    bus.Addr   = a;
    bus.DataIn = d;
    @(posedge Clk);
    #1;
    bus.RW     = ~rw;
    bus.Size   = ~sz;
    bus.Addr   = ~a;
    bus.DataIn = ~d;
  endtask

  task automatic req(input logic rw, input logic [1:0] sz,
                     input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_m,
                     input int hold);
    exp_t e;
    bit got;
    drive(rw, sz, a, d);
    if (rw && !exp_m) exp_dout = exp_rd;
    e.d = exp_dout;
    e.m = exp_m;
    e.c = cyc + LAT;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < LAT + 4 && !got; i++) begin
      @(negedge Clk);
      got = bus.MFC;
    end
    if (!got) begin
      chk(1'b0, "mfc_timeout", 32'(bus.MFC), 32'h1);
      sb.delete();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk(bus.MFC === 1'b1, "mfc_hold", 32'(bus.MFC), 32'h1);
      chk(bus.DataOut === exp_dout, "dout_hold", bus.DataOut, exp_dout);
    end
    @(negedge Clk);
    bus.Enable = 1'b0;
    @(negedge Clk);
    chk(bus.MFC === 1'b0, "mfc_fall", 32'(bus.MFC), 32'h0);
    chk(bus.Misaligned === 1'b0, "mis_fall", 32'(bus.Misaligned), 32'h0);
  endtask

  initial begin
    bus.Enable = 1'b0;
    bus.RW     = 1'b0;
    bus.Size   = 2'b00;
    bus.Addr   = 8'h0;
    bus.DataIn = 32'h0;
    #2;
    chk(bus.MFC === 1'b0, "rst_mfc", 32'(bus.MFC), 32'h0);
    chk(bus.Misaligned === 1'b0, "rst_mis", 32'(bus.Misaligned), 32'h0);
    chk(bus.DataOut === 32'h0, "rst_dout", bus.DataOut, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Clr = 1'b0;

    req(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    req(1'b1, 2'b00, 8'h10, 32'h0, 32'h000000DE, 1'b0, 0);
    req(1'b1, 2'b00, 8'h11, 32'h0, 32'h000000AD, 1'b0, 0);
    req(1'b1, 2'b00, 8'h12, 32'h0, 32'h000000BE, 1'b0, 0);
    req(1'b1, 2'b00, 8'h13, 32'h0, 32'h000000EF, 1'b0, 0);

    req(1'b0, 2'b10, 8'h20, 32'hAABBCCDD, 32'h0, 1'b0, 0);
    req(1'b0, 2'b01, 8'h22, 32'h00001234, 32'h0, 1'b0, 0);
    req(1'b1, 2'b10, 8'h20, 32'h0, 32'hAABB1234, 1'b0, 0);
    req(1'b1, 2'b01, 8'h20, 32'h0, 32'h0000AABB, 1'b0, 0);

    req(1'b0, 2'b10, 8'h40, 32'h01020304, 32'h0, 1'b0, 0);
    drive(1'b0, 2'b10, 8'h40, 32'h55555555);
    @(negedge Clk);
    bus.Enable = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge Clk);
      chk(bus.MFC === 1'b0, "abort_mfc", 32'(bus.MFC), 32'h0);
    end
    req(1'b1, 2'b10, 8'h40, 32'h0, 32'h01020304, 1'b0, 0);

    req(1'b1, 2'b10, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    req(1'b0, 2'b10, 8'h41, 32'h99887766, 32'h0, TRAP, 0);
    req(1'b1, 2'b10, 8'h40, 32'h0,
        TRAP ? 32'h01020304 : 32'h99887766, 1'b0, 0);
    req(1'b1, 2'b01, 8'h13, 32'h0, 32'h0000BEEF, TRAP, 0);

    req(1'b0, 2'b10, 8'h50, 32'h11223344, 32'h0, 1'b0, 0);
    req(1'b1, 2'b11, 8'h50, 32'h0, 32'h11223344, 1'b0, 0);
    drive(1'b0, 2'b10, 8'h50, 32'hCAFEF00D);
    #2;
    Clr = 1'b1;
    #1;
    chk(bus.MFC === 1'b0, "clr_mfc", 32'(bus.MFC), 32'h0);
    chk(bus.DataOut === 32'h0, "clr_dout", bus.DataOut, 32'h0);
    exp_dout = 32'h0;
    @(negedge Clk);
    bus.Enable = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
    repeat (LAT + 1) @(negedge Clk);
    chk(bus.MFC === 1'b0, "clr_idle_mfc", 32'(bus.MFC), 32'h0);
    req(1'b1, 2'b10, 8'h50, 32'h0, 32'h11223344, 1'b0, 0);

    repeat (2) @(negedge Clk);
    chk(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
